axil_lsu: RTL and testbench
===========================

AXIL_LSU -- requirements
Module: axil_lsu

Interface
REQ-001 Parameter DATA_W, default 32, bus/register data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter PROT, default 3'b000, constant driven on awprot and arprot.
REQ-004 Clocking: clk, input, 1, single clock, all logic on rising edge.
REQ-005 Reset: reset, input, 1, synchronous and active-high.
REQ-006 Request port:
- req_valid, input, 1
- req_ready, output, 1
- req_we, input, 1, 1 = store
- req_size, input, 2, 0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned, input, 1, zero-extend loads
- req_addr, input, ADDR_W
- req_wdata, input, DATA_W
REQ-007 Response port (no backpressure):
- resp_valid, output, 1
- resp_data, output, DATA_W
- resp_err, output, 1
REQ-008 AXI4-lite write:
- awvalid out 1, awready in 1, awaddress out ADDR_W, awprot out 3
- wvalid out 1, wready in 1, wdata out DATA_W, wrstrb out DATA_W/8
- bvalid in 1, bready out 1, bresp in 2
REQ-009 AXI4-lite read:
- arvalid out 1, arready in 1, araddress out ADDR_W, arprot out 3
- rvalid in 1, rready out 1, rdata in DATA_W, rresp in 2

Function
REQ-010 FSM states SHALL be IDLE, WRITE, WRESP, READ, RDATA and RESP.
REQ-011 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and only one request is outstanding.
REQ-012 A request SHALL be misaligned when any of these holds: size 1 with addr[0]; size 2 with addr[1:0] != 0; size 3 with addr[2:0] != 0; size 3 when DATA_W = 32.
REQ-013 A misaligned request SHALL go IDLE->RESP with no AXI activity, giving resp_err = 1 and resp_data = 0.
REQ-014 On an accepted aligned store, the FSM SHALL go to WRITE with awvalid = wvalid = 1 from the next cycle; each SHALL be held until its own handshake, in any order or together.
REQ-015 awaddress SHALL be req_addr with the low log2(DATA_W/8) bits cleared.
REQ-016 wdata SHALL be the low 2^size bytes of req_wdata replicated across all lanes.
REQ-017 wrstrb SHALL have the 2^size bits starting at the byte offset set and all other bits 0.
REQ-018 After both the AW and W handshakes, the FSM SHALL enter WRESP with bready = 1.
REQ-019 On bvalid in WRESP, the FSM SHALL enter RESP with resp_err = (bresp != 0) and resp_data = 0.
REQ-020 On an accepted aligned load, the FSM SHALL go to READ with arvalid = 1 and araddress aligned as in REQ-015, held until arready; it then enters RDATA with rready = 1.
REQ-021 On rvalid in RDATA, the unit SHALL extract the 2^size bytes at the byte offset from rdata and then:
- sign-extend to DATA_W, or zero-extend if req_unsigned
- set resp_err = (rresp != 0)
- force resp_data = 0 when resp_err = 1
REQ-022 RESP SHALL last exactly one cycle with resp_valid = 1, then return to IDLE; resp_valid SHALL be 0 in every other state.
REQ-023 Latency with slaves ready every cycle SHALL be 3 cycles from acceptance to resp_valid; a misaligned request SHALL take 1 cycle.
REQ-024 AXI payload outputs SHALL be held stable while the corresponding valid is 1.
REQ-025 Request inputs SHALL be registered at acceptance; changes afterwards SHALL have no effect.

Reset
REQ-026 While reset = 1, the unit SHALL hold:
- FSM in IDLE
- req_ready = 0
- awvalid = wvalid = bready = arvalid = rready = resp_valid = 0
- resp_data = 0, resp_err = 0, and all AXI address/data/strobe outputs = 0
REQ-027 req_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no response, and all valid/ready outputs SHALL be 0 in the following cycle.

Verification
REQ-029 DATA_W = 32, store byte, addr 0x1003, wdata 0xAB, slaves always ready -> awaddress 0x1000, wdata 0xABABABAB, wrstrb 4'b1000, resp_valid 3 cycles later with resp_err = 0.
REQ-030 Load half, addr 0x2002, rdata 0x8001_0000: signed -> resp_data 0xFFFF8001; req_unsigned -> 0x00008001.
REQ-031 Store word, awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid is held 4 cycles, and bready rises only after both handshakes.
REQ-032 Load word addr 0x3002 -> resp_valid next cycle with resp_err = 1, resp_data = 0, and no arvalid.
REQ-033 Load with rresp = 2'b10 -> resp_err = 1 and resp_data = 0; store with bresp = 2'b11 -> resp_err = 1.
REQ-034 DATA_W = 64, load dword addr 0x8 -> resp_data = rdata; reset asserted during RDATA -> rready = 0 next cycle and no resp_valid.

Source files
------------

// File: rtl/axil_lsu.sv
// rtl/axil_lsu.sv - AXI4-lite load/store unit with alignment check and load extension
module axil_lsu #(
  parameter int         DATA_W = 32,
  parameter int         ADDR_W = 32,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  // request port
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  // response port
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  // AXI4-lite write
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddress,
  output logic [2:0]          awprot,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wrstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  // AXI4-lite read
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddress,
  output logic [2:0]          arprot,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       wstrb_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_err_q;
  logic                accept;
  logic                req_mis;
  logic [ADDR_W-1:0]   addr_aligned;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    logic m;
    case (size)
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = (a[1:0] != 2'b00);
      default: m = (DATA_W == 32) || (a != 3'b000);
    endcase
    return m;
  endfunction

  // Low 2^size bytes copied into every byte lane.
  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    int nb;
    nb = 1 << size;
    r  = '0;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = d[(i % nb)*8 +: 8];
    return r;
  endfunction

  function automatic logic [NB-1:0] strobe(input logic [1:0] size, input int off);
    logic [NB-1:0] r;
    int nb;
    nb = 1 << size;
    for (int i = 0; i < NB; i++) r[i] = (i >= off) && (i < off + nb);
    return r;
  endfunction

  // Pull 2^size bytes from the lane at off and sign/zero extend to full width.
  function automatic logic [DATA_W-1:0] extract(input logic [1:0] size, input int off,
                                                input logic uns, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    logic sgn;
    int nbits;
    sh    = d >> (off * 8);
    nbits = 8 << size;
    sgn   = 1'b0;
    for (int i = 0; i < DATA_W; i++) if (i == nbits - 1) sgn = sh[i];
    for (int i = 0; i < DATA_W; i++) r[i] = (i < nbits) ? sh[i] : (!uns && sgn);
    return r;
  endfunction

  assign accept       = req_valid && (state_q == IDLE);
  assign req_mis      = misaligned(req_size, req_addr[2:0]);
  assign addr_aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign awprot       = PROT;
  assign arprot       = PROT;

  // State register plus request capture, handshake tracking and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q    <= req_addr;
        size_q    <= req_size;
        uns_q     <= req_unsigned;
        wdata_q   <= replicate(req_size, req_wdata);
        wstrb_q   <= strobe(req_size, int'(req_addr[OFF_W-1:0]));
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (req_mis) begin
          resp_err_q  <= 1'b1;
          resp_data_q <= '0;
        end
      end
      if (state_q == WRITE) begin
        if (awvalid && awready) aw_done_q <= 1'b1;
        if (wvalid && wready)   w_done_q  <= 1'b1;
      end
      if (state_q == WRESP && bvalid) begin
        resp_err_q  <= (bresp != 2'b00);
        resp_data_q <= '0;
      end
      if (state_q == RDATA && rvalid) begin
        resp_err_q  <= (rresp != 2'b00);
        resp_data_q <= (rresp != 2'b00) ? '0
                       : extract(size_q, int'(addr_q[OFF_W-1:0]), uns_q, rdata);
      end
    end
  end

  // Next-state and all outputs; everything is forced low while reset is asserted.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    awaddress  = addr_aligned;
    araddress  = addr_aligned;
    wdata      = wdata_q;
    wrstrb     = wstrb_q;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_mis)     state_d = RESP;
          else if (req_we) state_d = WRITE;
          else             state_d = READ;
        end
      end
      WRITE: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_d = RESP;
      end
      READ: begin
        arvalid = 1'b1;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = resp_data_q;
        resp_err   = resp_err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d    = IDLE;
      req_ready  = 1'b0;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_err   = 1'b0;
      awaddress  = '0;
      araddress  = '0;
      wdata      = '0;
      wrstrb     = '0;
    end
  end

endmodule

// File: tb/tb_axil_lsu.sv
// tb/tb_axil_lsu.sv - randomized self-checking bench for axil_lsu at 32 and 64 bit widths
module tb_axil_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel64;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  logic        a_req_ready, a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, a_resp_valid, a_resp_err;
  logic [31:0] a_awaddr, a_araddr, a_wdata, a_resp_data;
  logic [3:0]  a_wstrb;
  logic [2:0]  a_awprot, a_arprot;

  logic        b_req_ready, b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready, b_resp_valid, b_resp_err;
  logic [31:0] b_awaddr, b_araddr;
  logic [63:0] b_wdata, b_resp_data;
  logic [7:0]  b_wstrb;
  logic [2:0]  b_awprot, b_arprot;

  logic        m_req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_resp_valid, m_resp_err;
  logic [31:0] m_awaddr, m_araddr;
  logic [63:0] m_wdata, m_resp_data;
  logic [7:0]  m_wstrb;
  logic [2:0]  m_awprot, m_arprot;

  int n_vec = 0;
  int n_err = 0;

  axil_lsu #(.DATA_W(32), .ADDR_W(32), .PROT(3'b000)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel64), .req_ready(a_req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_err(a_resp_err),
    .awvalid(a_awvalid), .awready(awready), .awaddress(a_awaddr), .awprot(a_awprot),
    .wvalid(a_wvalid), .wready(wready), .wdata(a_wdata), .wrstrb(a_wstrb),
    .bvalid(bvalid), .bready(a_bready), .bresp(bresp),
    .arvalid(a_arvalid), .arready(arready), .araddress(a_araddr), .arprot(a_arprot),
    .rvalid(rvalid), .rready(a_rready), .rdata(rdata[31:0]), .rresp(rresp)
  );

  axil_lsu #(.DATA_W(64), .ADDR_W(32), .PROT(3'b101)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel64), .req_ready(b_req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_err(b_resp_err),
    .awvalid(b_awvalid), .awready(awready), .awaddress(b_awaddr), .awprot(b_awprot),
    .wvalid(b_wvalid), .wready(wready), .wdata(b_wdata), .wrstrb(b_wstrb),
    .bvalid(bvalid), .bready(b_bready), .bresp(bresp),
    .arvalid(b_arvalid), .arready(arready), .araddress(b_araddr), .arprot(b_arprot),
    .rvalid(rvalid), .rready(b_rready), .rdata(rdata), .rresp(rresp)
  );

  always_comb begin
    if (sel64) begin
      m_req_ready = b_req_ready; m_awvalid = b_awvalid; m_wvalid = b_wvalid; m_bready = b_bready;
      m_arvalid = b_arvalid; m_rready = b_rready; m_resp_valid = b_resp_valid; m_resp_err = b_resp_err;
      m_awaddr = b_awaddr; m_araddr = b_araddr; m_wdata = b_wdata; m_resp_data = b_resp_data;
      m_wstrb = b_wstrb; m_awprot = b_awprot; m_arprot = b_arprot;
    end else begin
      m_req_ready = a_req_ready; m_awvalid = a_awvalid; m_wvalid = a_wvalid; m_bready = a_bready;
      m_arvalid = a_arvalid; m_rready = a_rready; m_resp_valid = a_resp_valid; m_resp_err = a_resp_err;
      m_awaddr = a_awaddr; m_araddr = a_araddr; m_wdata = {32'h0, a_wdata};
      m_resp_data = {32'h0, a_resp_data};
      m_wstrb = {4'h0, a_wstrb}; m_awprot = a_awprot; m_arprot = a_arprot;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] vec_m();
    return {m_req_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_resp_valid};
  endfunction

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
  endtask

  // One request with programmable slave delays; expectations come from the reference rules.
  task automatic run(input bit w64, input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                     input logic [1:0] rsp, input int aw_dly, input int w_dly, input int b_dly,
                     input int ar_dly, input int r_dly);
    int dw, bpl, nb, off, haw, hw, hm, hb, har, hr, resp_c, bcnt, rcnt;
    bit mis, exp_err;
    logic [63:0] dmask, emask, val, exp_wd, exp_strb, rdv, v, exp_data;
    logic [31:0] exp_a;
    logic [6:0] ev;

    dw    = w64 ? 64 : 32;
    bpl   = dw / 8;
    nb    = 1 << size;
    off   = int'(addr % bpl);
    mis   = (addr % nb != 0) || (nb > bpl);
    dmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    emask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
    exp_a = addr - (addr % bpl);
    val   = wd & emask;
    exp_wd = 64'h0;
    for (int k = 0; k < bpl / nb; k++) exp_wd |= val << (k * nb * 8);
    exp_strb = ((64'd1 << nb) - 64'd1) << off;
    rdv = rd & dmask;
    v   = (rdv >> (off * 8)) & emask;
    if (!uns && nb < 8 && v[nb*8-1]) v |= ~emask;
    v &= dmask;
    exp_err  = mis ? 1'b1 : (rsp != 2'b00);
    exp_data = (we || exp_err) ? 64'h0 : v;

    haw = 0; hw = 0; hm = 0; hb = 0; har = 0; hr = 0;
    if (mis) resp_c = 1;
    else if (we) begin
      haw = 1 + aw_dly; hw = 1 + w_dly; hm = (haw > hw) ? haw : hw;
      hb = hm + 1 + b_dly; resp_c = hb + 1;
    end else begin
      har = 1 + ar_dly; hr = har + 1 + r_dly; resp_c = hr + 1;
    end

    @(negedge clk);
    sel64 = w64; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr;
    req_wdata = wd; rdata = rdv; bresp = rsp; rresp = rsp; slave_idle();
    req_valid = 1;
    check("req_ready_idle", m_req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = $urandom; req_wdata = {$urandom, $urandom};
    bcnt = 0; rcnt = 0;
    for (int c = 1; c <= resp_c + 1; c++) begin
      if (c <= resp_c) begin
        ev = {1'b0,
              !mis && we && c <= haw,
              !mis && we && c <= hw,
              !mis && we && c > hm && c <= hb,
              !mis && !we && c <= har,
              !mis && !we && c > har && c <= hr,
              c == resp_c};
        check("valids", vec_m(), ev);
      end else begin
        check("back_to_idle", vec_m(), 7'b1000000);
      end
      if (c == 1) begin
        check("awprot", m_awprot, w64 ? 3'b101 : 3'b000);
        check("arprot", m_arprot, w64 ? 3'b101 : 3'b000);
      end
      if (m_awvalid) check("awaddress", m_awaddr, exp_a);
      if (m_arvalid) check("araddress", m_araddr, exp_a);
      if (m_wvalid) begin
        check("wdata", m_wdata, exp_wd);
        check("wrstrb", m_wstrb, exp_strb);
      end
      if (c == resp_c) begin
        check("resp_err", m_resp_err, exp_err);
        check("resp_data", m_resp_data, exp_data);
      end
      awready = (c >= 1 + aw_dly);
      wready  = (c >= 1 + w_dly);
      arready = (c >= 1 + ar_dly);
      bvalid  = m_bready && (bcnt >= b_dly);
      rvalid  = m_rready && (rcnt >= r_dly);
      if (m_bready) bcnt++;
      if (m_rready) rcnt++;
      if (c == resp_c + 1) slave_idle();
      @(posedge clk); #1;
    end
    slave_idle();
  endtask

  // Reset landing in RDATA on the 64-bit unit: transaction dropped, no response.
  task automatic reset_in_rdata();
    @(negedge clk);
    sel64 = 1; req_we = 0; req_size = 2'd3; req_unsigned = 0; req_addr = 32'h8;
    rdata = 64'h0123_4567_89AB_CDEF; rresp = 0; slave_idle(); arready = 1;
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    check("rst_pre_rdata", vec_m(), 7'b0000010);
    reset = 1;
    #1;
    check("rst_held_valids", vec_m(), 7'b0);
    check("rst_held_araddr", m_araddr, 32'h0);
    @(posedge clk); #1;
    check("rst_next_valids", vec_m(), 7'b0);
    rvalid = 1;
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_after_valids", vec_m(), 7'b1000000);
    end
    slave_idle();
  endtask

  initial begin
    int size_r, off_r;
    bit w64_r;
    reset = 1; sel64 = 0; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; rdata = 0; bresp = 0; rresp = 0; slave_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valids32", {a_req_ready, a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, a_resp_valid}, 7'b0);
    check("reset_valids64", {b_req_ready, b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready, b_resp_valid}, 7'b0);
    check("reset_payload32", {a_awaddr, a_wdata}, 64'h0);
    check("reset_payload64", b_wdata | {32'h0, b_awaddr} | {56'h0, b_wstrb}, 64'h0);
    check("reset_resp", {a_resp_err, b_resp_err, a_resp_data, b_resp_data[31:0]}, 64'h0);
    reset = 0;
    @(posedge clk); #1;
    check("ready_after_reset32", a_req_ready, 1);
    check("ready_after_reset64", b_req_ready, 1);

    // directed cases
    run(0, 1, 2'd0, 0, 32'h1003, 64'h0000_00AB, 64'h0, 2'b00, 0, 0, 0, 0, 0);
    run(0, 0, 2'd1, 0, 32'h2002, 64'h0, 64'h8001_0000, 2'b00, 0, 0, 0, 0, 0);
    run(0, 0, 2'd1, 1, 32'h2002, 64'h0, 64'h8001_0000, 2'b00, 0, 0, 0, 0, 0);
    run(0, 1, 2'd2, 0, 32'h4000, 64'hDEAD_BEEF, 64'h0, 2'b00, 3, 0, 0, 0, 0);
    run(0, 0, 2'd2, 0, 32'h3002, 64'h0, 64'h1234_5678, 2'b00, 0, 0, 0, 0, 0);
    run(0, 0, 2'd2, 0, 32'h3004, 64'h0, 64'h1234_5678, 2'b10, 0, 0, 0, 0, 0);
    run(0, 1, 2'd2, 0, 32'h3004, 64'h5555_AAAA, 64'h0, 2'b11, 0, 0, 0, 0, 0);
    run(0, 0, 2'd3, 0, 32'h0008, 64'h0, 64'h1, 2'b00, 0, 0, 0, 0, 0);
    run(1, 0, 2'd3, 0, 32'h0008, 64'h0, 64'hFEDC_BA98_7654_3210, 2'b00, 0, 0, 0, 0, 0);
    run(1, 1, 2'd1, 0, 32'h0106, 64'h0000_C3A5, 64'h0, 2'b00, 0, 2, 1, 0, 0);
    reset_in_rdata();

    // randomized traffic on both widths
    for (int n = 0; n < 240; n++) begin
      w64_r  = 1'($urandom);
      size_r = $urandom_range(0, 3);
      off_r  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : (((1 << size_r) * $urandom_range(0, 7)) & 7);
      run(w64_r, 1'($urandom), 2'(size_r), 1'($urandom),
          (($urandom & 32'h0000_FFF8) | 32'(off_r)), {$urandom, $urandom}, {$urandom, $urandom},
          ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
